plot_receiver: RTL
==================

PLOT_RECEIVER -- requirements
Module: plot_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, 8, number of pending pixel writes buffered (power of two, 2..64).
REQ-002 Parameter SCREEN_W, 160, pixel columns accepted.
REQ-003 Parameter SCREEN_H, 120, pixel rows accepted.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 x  input  8  pixel column from drawer.
REQ-008 y  input  7  pixel row from drawer.
REQ-009 colour  input  3  pixel RGB (1 bit per channel).
REQ-010 plot  input  1  write request; each high cycle is one pixel.
REQ-011 clear  input  1  request to fill the whole frame with clear_colour.
REQ-012 clear_colour  input  3  fill colour, sampled when clear is accepted.
REQ-013 fb_addr  output  15  framebuffer word address.
REQ-014 fb_data  output  3  framebuffer write data.
REQ-015 fb_we  output  1  write valid toward framebuffer.
REQ-016 fb_ready  input  1  framebuffer accepts write this cycle.
REQ-017 busy  output  1  FIFO non-empty, clear pending, or clear in progress.
REQ-018 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-019 overflow  output  1  sticky: an in-bounds plot was dropped.
REQ-020 oob_count  output  8  saturating count of out-of-bounds plots.

Function
REQ-021 Plot with x>=SCREEN_W or y>=SCREEN_H SHALL be discarded and increment oob_count, saturating at 255.
REQ-022 In-bounds plot SHALL push {addr, colour} into FIFO, addr = y*SCREEN_W + x, computed as (y<<7)+(y<<5)+x for the default width, 15 bits, no truncation.
REQ-023 Push when full SHALL be accepted only if a pop occurs the same cycle; otherwise drop and set overflow until reset.
REQ-024 A write transfer SHALL occur on any cycle with fb_we=1 and fb_ready=1; FIFO pops (state DRAIN) or clear address advances (state CLEAR).
REQ-025 While fb_we=1 and fb_ready=0, fb_addr/fb_data/fb_we SHALL hold stable.
REQ-026 Latency: plot sampled at edge N into empty FIFO in DRAIN SHALL give fb_we=1 with its addr/colour after edge N+1 (registered FIFO output).
REQ-027 States: DRAIN (reset), CLEAR_WAIT, CLEAR.
REQ-028 DRAIN: fb_we = FIFO non-empty; clear=1 captures clear_colour, goes to CLEAR_WAIT.
REQ-029 CLEAR_WAIT: FIFO keeps draining; enter CLEAR on the cycle FIFO is empty, clear address = 0.
REQ-030 CLEAR: fb_we=1, fb_addr=clear address, fb_data=captured colour; address increments per transfer; transfer at address SCREEN_W*SCREEN_H-1 (19199) returns to DRAIN.
REQ-031 Plots arriving in CLEAR_WAIT/CLEAR SHALL still be bounds-checked and enqueued; they drain after CLEAR completes.
REQ-032 clear asserted outside DRAIN SHALL be ignored; clear and plot same cycle: both accepted.
REQ-033 busy SHALL deassert on the cycle after the last transfer with FIFO empty in DRAIN.

Reset
REQ-034 resetn low SHALL asynchronously force: state DRAIN, FIFO empty, clear address 0, fb_we=0, fb_addr=0, fb_data=0, busy=0, full=0, overflow=0, oob_count=0.
REQ-035 Reset mid-CLEAR or mid-drain SHALL abandon all pending writes; no write occurs until a new plot/clear after release.

Structure
REQ-036 Shared package plot_pkg SHALL hold SCREEN_W, SCREEN_H, FB_PIXELS (19200), FB_ADDR_W (15), COLOUR_W (3) and the state enumeration.
REQ-037 FIFO SHALL be a sub-module plot_fifo (synchronous push/pop, registered head, full/empty flags, async active-low reset).

Verification
REQ-038 Single plot x=3,y=2,colour=7 with fb_ready=1 -> one cycle later fb_we=1, fb_addr=323, fb_data=7; busy falls next cycle.
REQ-039 Plots x=160,y=0 and x=0,y=120 -> no fb_we, oob_count=2; 300 such plots -> oob_count=255.
REQ-040 fb_ready=0, 10 consecutive in-bounds plots (depth 8) -> full=1 after 8, overflow=1, then fb_ready=1 drains exactly first 8 in order.
REQ-041 clear with clear_colour=4, fb_ready=1 -> 19200 writes addr 0..19199 data 4, then DRAIN; a plot x=1,y=1 sent mid-clear written (addr 161) after addr 19199.
REQ-042 fb_ready toggling every cycle during drain -> outputs stable while stalled, no lost or duplicated writes.
REQ-043 resetn low at clear address 5000 -> all outputs 0 asynchronously; after release no writes without new stimulus.

Source files
------------

// File: rtl/plot_pkg.sv
// Screen geometry, framebuffer widths and the receiver state set,
// shared by the plot receiver and its tests.
package plot_pkg;
  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned FB_PIXELS = SCREEN_W * SCREEN_H;
  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned COLOUR_W  = 3;

  typedef enum logic [1:0] {
    DRAIN,
    CLEAR_WAIT,
    CLEAR
  } plot_state_t;
endpackage

// File: rtl/plot_fifo.sv
// Pixel-write FIFO with a registered head entry; count includes the head,
// so an entry becomes visible at the head one cycle after it is pushed.
module plot_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    mem_count;
  logic             pop_ok;
  logic             push_ok;
  logic             load;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign mem_count = count - CW'(head_valid);
  assign pop_ok    = pop & head_valid;
  assign push_ok   = push & (~full | pop_ok);
  // Refill the head from storage whenever it is vacant or leaving this cycle.
  assign load      = (mem_count != '0) & (~head_valid | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        head       <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
        head_valid <= 1'b1;
      end else if (pop_ok) begin
        head_valid <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/plot_receiver.sv
// Bounds-checks pixel plots, buffers them toward the framebuffer and
// performs whole-frame clears once previously queued pixels have drained.
module plot_receiver
  import plot_pkg::FB_ADDR_W, plot_pkg::COLOUR_W, plot_pkg::plot_state_t,
         plot_pkg::DRAIN, plot_pkg::CLEAR_WAIT, plot_pkg::CLEAR;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SCREEN_W   = plot_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H   = plot_pkg::SCREEN_H
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           x,
  input  logic [6:0]           y,
  input  logic [COLOUR_W-1:0]  colour,
  input  logic                 plot,
  input  logic                 clear,
  input  logic [COLOUR_W-1:0]  clear_colour,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOUR_W-1:0]  fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready,
  output logic                 busy,
  output logic                 full,
  output logic                 overflow,
  output logic [7:0]           oob_count
);
  localparam int unsigned LAST_ADDR = SCREEN_W * SCREEN_H - 1;

  plot_state_t                   state;
  plot_state_t                   state_next;
  logic [FB_ADDR_W-1:0]          clr_addr;
  logic [COLOUR_W-1:0]           clr_colour;
  logic [FB_ADDR_W+COLOUR_W-1:0] head;
  logic                          head_valid;
  logic                          empty;
  logic                          in_bounds;
  logic [FB_ADDR_W-1:0]          plot_addr;
  logic                          push;
  logic                          pop;
  logic                          clr_last;

  assign in_bounds = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  assign plot_addr = FB_ADDR_W'(32'(y) * SCREEN_W + 32'(x));
  assign push      = plot & in_bounds;
  assign pop       = head_valid & fb_ready & (state != CLEAR);
  assign clr_last  = (clr_addr == FB_ADDR_W'(LAST_ADDR));

  plot_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(FB_ADDR_W + COLOUR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (push),
    .push_data ({plot_addr, colour}),
    .pop       (pop),
    .head      (head),
    .head_valid(head_valid),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= DRAIN;
      clr_addr   <= '0;
      clr_colour <= '0;
      overflow   <= 1'b0;
      oob_count  <= '0;
    end else begin
      state <= state_next;
      if (state == DRAIN && clear) clr_colour <= clear_colour;
      if (state == CLEAR) begin
        if (fb_ready) clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
      end else begin
        clr_addr <= '0;
      end
      if (push && full && !pop) overflow <= 1'b1;
      if (plot && !in_bounds && oob_count != '1) oob_count <= oob_count + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DRAIN:      if (clear) state_next = CLEAR_WAIT;
      CLEAR_WAIT: if (empty) state_next = CLEAR;
      CLEAR:      if (fb_ready && clr_last) state_next = DRAIN;
      default:    state_next = DRAIN;
    endcase
  end

  // The clear engine owns the write port outright; queued plots wait behind it.
  always_comb begin
    fb_we   = head_valid;
    fb_addr = head[FB_ADDR_W+COLOUR_W-1:COLOUR_W];
    fb_data = head[COLOUR_W-1:0];
    if (state == CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = clr_addr;
      fb_data = clr_colour;
    end
  end

  assign busy = ~empty | (state != DRAIN);
endmodule
